write_data: RTL and testbench

WRITE_DATA -- requirements
Module: write_data

---
 rtl/write_data.sv | 91 +++++++++
 tb/tb_write_data.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/write_data.sv
// Two-beat memory writer: captures two operands and a base address on start,
// then writes a at base and b at base+1 through a valid/ready write port.
module write_data #(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic [SIZE_ADDR-1:0] i_base_addr,
  input  logic                 i_wr_ready,
  output logic                 o_wr_en,
  output logic [SIZE_ADDR-1:0] o_addr,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [SIZE_DATA-1:0] data_b_q;
  logic [SIZE_ADDR-1:0] base_q;

  assign dbg_state = state;

  // Handshake: a beat transfers on a rising edge where o_wr_en and i_wr_ready
  // are both high; while ready is low, o_wr_en/o_addr/o_data hold unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      data_b_q <= '0;
      base_q   <= '0;
      o_wr_en  <= 1'b0;
      o_addr   <= '0;
      o_data   <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            data_b_q <= i_data_b;
            base_q   <= i_base_addr;
            o_wr_en  <= 1'b1;
            o_addr   <= i_base_addr;
            o_data   <= i_data_a;
            o_busy   <= 1'b1;
            state    <= WR_A;
          end
        end
        WR_A: begin
          if (i_wr_ready) begin
            // Unsigned add in SIZE_ADDR bits wraps an all-ones base to zero.
            o_addr <= base_q + SIZE_ADDR'(1);
            o_data <= data_b_q;
            state  <= WR_B;
          end
        end
        WR_B: begin
          if (i_wr_ready) begin
            o_wr_en <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_wr_en <= 1'b0;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_data.sv
// Directed and randomized transactions against a transaction-level model of
// the two-beat writer: expected beats, latency and done/beat totals.
module tb_write_data;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] base_addr;
  logic       wr_ready;
  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  int beat_cnt  = 0;
  int done_cnt  = 0;
  int exp_beats = 0;
  int exp_dones = 0;

  always #5 clk = ~clk;

  write_data #(.SIZE_DATA(8), .SIZE_ADDR(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_data_a(data_a), .i_data_b(data_b), .i_base_addr(base_addr),
    .i_wr_ready(wr_ready),
    .o_wr_en(wr_en), .o_addr(addr), .o_data(data),
    .o_busy(busy), .o_done(done), .dbg_state(dbg_state)
  );

  // Monitor: counts completed beats and done pulses between edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en && wr_ready) beat_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic scramble();
    data_a    = 8'($urandom);
    data_b    = 8'($urandom);
    base_addr = 8'($urandom);
  endtask

  // One transaction from IDLE: sa/sb stall cycles in WR_A/WR_B, poke pulses
  // start with garbage operands while busy, hold keeps start high throughout.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] base, input int sa, input int sb,
                         input bit poke, input bit hold);
    logic [7:0] base_p1;
    int         t0;
    base_p1   = 8'((32'(base) + 1) % 256);
    start     = 1'b1;
    data_a    = a;
    data_b    = b;
    base_addr = base;
    wr_ready  = (sa == 0);
    t0        = cyc;
    tick();
    for (int k = 0; k <= sa; k++) begin
      chk("beat_a_wr_en", 32'(wr_en), 32'd1);
      chk("beat_a_addr", 32'(addr), 32'(base));
      chk("beat_a_data", 32'(data), 32'(a));
      chk("beat_a_busy", 32'(busy), 32'd1);
      scramble();
      start    = hold | (poke & $urandom_range(0, 1) == 1);
      wr_ready = (k == sa);
      if (k == sa) wr_ready = 1'b1;
      tick();
    end
    wr_ready = (sb == 0);
    for (int k = 0; k <= sb; k++) begin
      chk("beat_b_wr_en", 32'(wr_en), 32'd1);
      chk("beat_b_addr", 32'(addr), 32'(base_p1));
      chk("beat_b_data", 32'(data), 32'(b));
      chk("beat_b_done", 32'(done), 32'd0);
      scramble();
      start    = hold | poke;
      wr_ready = (k == sb);
      tick();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_wr_en", 32'(wr_en), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("latency", 32'(cyc - t0), 32'(3 + sa + sb));
    start    = hold;
    wr_ready = 1'($urandom_range(0, 1));
    tick();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_wr_en", 32'(wr_en), 32'd0);
    exp_beats += 2;
    exp_dones += 1;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    data_a    = 8'h55;
    data_b    = 8'h66;
    base_addr = 8'h77;
    wr_ready  = 1'b1;
    tick();
    tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    run_txn(8'h3C, 8'hA5, 8'h10, 0, 0, 1'b0, 1'b0);
    run_txn(8'h3C, 8'hA5, 8'h10, 2, 0, 1'b0, 1'b0);
    run_txn(8'h11, 8'h22, 8'hFF, 0, 0, 1'b0, 1'b0);
    run_txn(8'h3C, 8'hA5, 8'h10, 0, 1, 1'b1, 1'b0);
    run_txn(8'hC3, 8'h5A, 8'h80, 0, 0, 1'b0, 1'b1);
    run_txn(8'h01, 8'h02, 8'h03, 0, 0, 1'b0, 1'b0);

    // Reset during WR_B aborts the transaction, start is ignored under reset.
    start     = 1'b1;
    data_a    = 8'h3C;
    data_b    = 8'hA5;
    base_addr = 8'h10;
    wr_ready  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_abort_addr", 32'(addr), 32'h11);
    exp_beats += 1;
    wr_ready = 1'b0;
    rst      = 1'b1;
    start    = 1'b1;
    tick();
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_data", 32'(data), 32'd0);
    rst      = 1'b0;
    start    = 1'b0;
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_beat", 32'(wr_en), 32'd0);
    end

    for (int n = 0; n < 20; n++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'b0);
    end
    tick();
    chk("beat_total", 32'(beat_cnt), 32'(exp_beats));
    chk("done_total", 32'(done_cnt), 32'(exp_dones));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
